req_arbiter_4: RTL

- Sequential 4-requester arbiter that shares one resource.
- Requester 3 has the highest static priority; requester 0 has the lowest.
- Registers a one-hot grant plus an encoded grant_id and valid flag (y1/y0/valid style).
- Optional round-robin rotation and a hold-timeout watchdog keep a requester from monopolising the resource.

---
 rtl/req_arbiter_4.sv | 76 +++++++
 1 files changed

// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-requester arbiter with optional round-robin rotation and hold-timeout watchdog.
// Grants are registered; every release spends at least one cycle idle before the next grant.
module req_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter bit          RR_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    state_t     state_q;
    logic [3:0] grant_q;
    logic [1:0] grant_id_q;
    logic [1:0] last_id_q;
    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;
    logic       timeout_q;
    logic [1:0] start_id;
    logic [1:0] win_id;
    logic       rel_done;
    logic       rel_drop;
    logic       rel_hold;
    logic       release_now;
    // Search downward from start_id; the lowest offset that hits wins, so scan it last.
    always_comb begin
        start_id = RR_EN ? last_id_q - 2'd1 : 2'd3;
        win_id   = start_id;
        for (int k = 3; k >= 0; k--)
            if (req[start_id - 2'(k)]) win_id = start_id - 2'(k);
    end
    assign rel_done    = done;
    assign rel_drop    = ~req[grant_id_q];
    assign rel_hold    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign release_now = rel_done | rel_drop | rel_hold;
    assign hold_cnt_d  = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + 8'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            last_id_q  <= 2'd0;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == IDLE) begin
                if (|req) begin
                    grant_q    <= 4'b0001 << win_id;
                    grant_id_q <= win_id;
                    hold_cnt_q <= 8'd0;
                    state_q    <= BUSY;
                end
            end else if (release_now) begin
                grant_q    <= 4'b0000;
                grant_id_q <= 2'd0;
                last_id_q  <= grant_id_q;
                // Only a pure watchdog release is reported as a timeout.
                timeout_q  <= rel_hold & ~rel_done & ~rel_drop;
                state_q    <= IDLE;
            end else begin
                hold_cnt_q <= hold_cnt_d;
            end
        end
    end
    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;
endmodule
